multdiv_iter: RTL and testbench
===============================

MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL have parameter ITER, default 32: number of iteration cycles per operation.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_operandA  input  32  signed multiplicand/dividend; sampled only on a start cycle.
REQ-006 SHALL have port data_operandB  input  32  signed multiplier/divisor; sampled only on a start cycle.
REQ-007 SHALL have port ctrl_MULT  input  1  one-cycle pulse that starts a signed multiply.
REQ-008 SHALL have port ctrl_DIV  input  1  one-cycle pulse that starts a signed divide.
REQ-009 SHALL have port data_result  output  32  registered result; held stable until the next start.
REQ-010 SHALL have port data_exception  output  1  registered; valid while data_resultRDY=1, held with data_result.
REQ-011 SHALL have port data_resultRDY  output  1  registered one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE; transitions:
- IDLE->MUL on ctrl_MULT.
- IDLE->DIV on ctrl_DIV with B!=0.
- IDLE->DONE on ctrl_DIV with B==0.
- MUL/DIV->DONE when the iteration counter reaches ITER.
- DONE->IDLE unconditionally.
REQ-013 SHALL sample operands on the start cycle, so operand changes after that cycle have no effect.
REQ-014 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are both high in one cycle.
REQ-015 SHALL, on a start in any state including MUL/DIV/DONE, abort the current operation without asserting data_resultRDY, reload the operands, and clear the counter.
REQ-016 SHALL compute multiply as radix-2 Booth over a 65-bit {acc,Q,q-1} register, one step per cycle.
REQ-017 SHALL output the low 32 product bits as the multiply result, with exception=1 iff the 64-bit product is not the sign-extension of bit 31.
REQ-018 SHALL compute divide by restoring division on operand magnitudes, one quotient bit per cycle.
REQ-019 SHALL truncate the quotient toward zero and negate it when sign(A)^sign(B)=1; remainder is discarded.
REQ-020 SHALL, for divide by zero, produce result 0x00000000 and exception=1, with data_resultRDY in the cycle after the start.
REQ-021 SHALL, for 0x80000000 / 0xFFFFFFFF, produce result 0x80000000 and exception=1.
REQ-022 SHALL, for a start sampled at edge N, assert data_resultRDY for exactly the cycle following edge N+ITER+1 (MUL and non-zero DIV).
REQ-023 SHALL update data_result and data_exception on the same edge that raises data_resultRDY, and hold them until the next completion or reset.
REQ-024 SHALL keep data_resultRDY low in IDLE, MUL and DIV.

Reset
REQ-025 SHALL, while reset=1 and independent of clock, force the state to IDLE, the counter to 0, the internal registers to 0, and data_result, data_exception and data_resultRDY to 0.
REQ-026 SHALL, when reset is asserted mid-operation, discard the operation and never emit data_resultRDY for it.
REQ-027 SHALL ignore start pulses coincident with reset=1.

Structure
REQ-028 SHALL take the state enum, the WIDTH/ITER constants and the exception encodings from the shared package multdiv_pkg.
REQ-029 SHALL instantiate one sub-module, multdiv_counter: a 6-bit up-counter with synchronous clear, async reset and a terminal-count output at ITER.
REQ-030 SHALL use a single shared 65-bit working register for both multiply and divide, selected by state.

Verification
REQ-031 SHALL cover a MULT pulse with A=7, B=-3 -> RDY exactly 33 cycles after start, result 0xFFFFFFEB, exception 0.
REQ-032 SHALL cover a MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1.
REQ-033 SHALL cover a DIV with A=-7, B=2 -> result 0xFFFFFFFD, exception 0; and a DIV with A=5, B=0 -> RDY on the next cycle, result 0, exception 1.
REQ-034 SHALL cover a DIV of 100/7 followed, 10 cycles later, by a MULT of 6*7 -> no RDY for the divide; RDY 33 cycles after the MULT with result 42.
REQ-035 SHALL cover reset asserted at cycle 15 of a multiply -> all outputs 0 immediately and no RDY for that multiply; a MULT after reset with A=2, B=3 -> result 6.
REQ-036 SHALL cover ctrl_MULT and ctrl_DIV high together with A=9, B=3 -> result 27 (multiply executed).

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants, FSM state encodings and helpers for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_pkg;

  localparam int WIDTH_C = 32;
  localparam int ITER_C  = 32;
  localparam int CNT_W   = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic EXC_NONE = 1'b0;
  localparam logic EXC_OVF  = 1'b1;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned 2^31.
  function automatic logic [WIDTH_C-1:0] mag(input logic [WIDTH_C-1:0] v);
    return v[WIDTH_C-1] ? -v : v;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: 6-bit up-counter with synchronous clear and terminal count at ITER.
// Latency: count visible one cycle after enable; tc_o is combinational from the count.
// Backpressure: none; holds its value when en_i is low.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int ITER = ITER_C
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment so a restart always begins from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 6'(ITER));

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (restoring) sharing one 65-bit register.
// Latency: ITER+1 cycles from start edge to result edge; divide-by-zero completes on the start edge.
// Backpressure: none; a new start pulse aborts any operation in flight and restarts.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_C,
  parameter int ITER  = ITER_C
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int WW = 2 * WIDTH + 1;

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    work_q, work_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             start;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [WIDTH:0]   booth_sum, div_rem, div_diff;
  logic [WW-1:0]    booth_nxt, div_nxt;
  logic [WIDTH-1:0] quot;

  assign start = ctrl_MULT | ctrl_DIV;
  assign quot  = work_q[WIDTH-1:0];

  multdiv_counter #(.ITER(ITER)) u_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  // Booth step: add/subtract in WIDTH+1 bits so the shifted-in sign is exact even for M = -2^31.
  always_comb begin
    booth_sum = {work_q[WW-1], work_q[WW-1:WIDTH+1]};
    case (work_q[1:0])
      2'b01:   booth_sum = booth_sum + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = booth_sum - {m_q[WIDTH-1], m_q};
      default: booth_sum = booth_sum;
    endcase
    booth_nxt = {booth_sum, work_q[WIDTH:1]};
  end

  // Restoring division step: shift {rem, quot} left, keep the trial subtraction if it stays non-negative.
  always_comb begin
    div_nxt  = {work_q[WW-2:0], 1'b0};
    div_rem  = div_nxt[WW-1:WIDTH];
    div_diff = div_rem - {1'b0, m_q};
    if (!div_diff[WIDTH]) begin
      div_nxt[WW-1:WIDTH] = div_diff;
      div_nxt[0]          = 1'b1;
    end
  end

  // Control: a start always restarts; otherwise iterate until terminal count, then publish once.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    m_d      = m_q;
    neg_d    = neg_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (start) begin
      cnt_clr = 1'b1;
      if (ctrl_MULT) begin
        state_d = S_MUL;
        work_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        m_d     = data_operandA;
        neg_d   = 1'b0;
      end else if (data_operandB == '0) begin
        state_d  = S_DONE;
        work_d   = '0;
        m_d      = '0;
        neg_d    = 1'b0;
        result_d = '0;
        exc_d    = EXC_OVF;
        rdy_d    = 1'b1;
      end else begin
        state_d = S_DIV;
        work_d  = {{(WIDTH+1){1'b0}}, mag(data_operandA)};
        m_d     = mag(data_operandB);
        neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      end
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_tc) begin
            state_d  = S_DONE;
            result_d = work_q[WIDTH:1];
            exc_d    = (work_q[WW-1:WIDTH+1] != {WIDTH{work_q[WIDTH]}}) ? EXC_OVF : EXC_NONE;
            rdy_d    = 1'b1;
          end else begin
            work_d = booth_nxt;
            cnt_en = 1'b1;
          end
        end
        S_DIV: begin
          if (cnt_tc) begin
            state_d  = S_DONE;
            result_d = neg_q ? -quot : quot;
            // Only |A|=2^31, |B|=1 with equal signs yields an unrepresentable positive quotient.
            exc_d    = (!neg_q && quot[WIDTH-1]) ? EXC_OVF : EXC_NONE;
            rdy_d    = 1'b1;
          end else begin
            work_d = div_nxt;
            cnt_en = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      m_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      m_q      <= m_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: stimulus pushes expected results, a negedge monitor checks them.
// Latency: expects completion ITER+1 cycles after the start edge (same edge for divide by zero).
// Backpressure: a new start drops the outstanding expectation, since the DUT aborts it.
module tb_multdiv_iter;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        c_mul = 1'b0;
  logic        c_div = 1'b0;
  logic [31:0] res;
  logic        exc;
  logic        rdy;

  multdiv_iter #(.WIDTH(32), .ITER(ITER)) dut (
    .clock          (clk),
    .reset          (rst),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (c_mul),
    .ctrl_DIV       (c_div),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    bit          e;
    int          due;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          passes = 0;
  int          op_id  = 0;
  logic [31:0] last_r = '0;
  bit          last_e = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, want, $time);
  endtask

  // Reference behaviour from plain signed arithmetic.
  function automatic void ref_model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit e);
    logic signed [31:0] sa, sb;
    longint p;
    sa = a;
    sb = b;
    if (is_mul) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = sa / sb;
      e = 1'b0;
    end
  endfunction

  // Monitor: compare on each completion pulse, flag late/spurious pulses and check output hold.
  always @(negedge clk) begin
    exp_t t;
    if (!rst) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        t = sbq.pop_front();
        chk(1'b0, $sformatf("missed_rdy op%0d", t.id), 64'(cyc), 64'(t.due));
      end
      if (rdy) begin
        if (sbq.size() == 0) begin
          chk(1'b0, "spurious_rdy", 64'(rdy), 64'd0);
        end else begin
          t = sbq.pop_front();
          chk(t.due == cyc, $sformatf("rdy_cycle op%0d", t.id), 64'(cyc), 64'(t.due));
          chk(res == t.r, $sformatf("result op%0d", t.id), 64'(res), 64'(t.r));
          chk(exc == t.e, $sformatf("exception op%0d", t.id), 64'(exc), 64'(t.e));
          last_r = t.r;
          last_e = t.e;
        end
      end else begin
        chk(res == last_r, "hold_result", 64'(res), 64'(last_r));
        chk(exc == last_e, "hold_exception", 64'(exc), 64'(last_e));
      end
    end
  end

  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    exp_t        drop;
    logic [31:0] r;
    bit          x;
    int          n;
    @(negedge clk);
    n = cyc + 1;
    while (sbq.size() > 0 && sbq[sbq.size()-1].due >= n) drop = sbq.pop_back();
    op_a  = a;
    op_b  = b;
    c_mul = m;
    c_div = d;
    ref_model(m, a, b, r, x);
    e.r   = r;
    e.e   = x;
    e.due = n + ((m || b != 32'd0) ? ITER + 1 : 0);
    e.id  = op_id;
    op_id++;
    sbq.push_back(e);
    @(negedge clk);
    c_mul = 1'b0;
    c_div = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(sbq.size() == 0, "drain_timeout", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk(res == 32'd0, "reset_result", 64'(res), 64'd0);
    chk(exc == 1'b0, "reset_exception", 64'(exc), 64'd0);
    chk(rdy == 1'b0, "reset_rdy", 64'(rdy), 64'd0);
    #2 rst = 1'b0;

    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);           wait_done();
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);   wait_done();
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);           wait_done();
    issue(1'b0, 1'b1, 32'd5, 32'd0);                   wait_done();
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done();

    // Divide aborted ten cycles in by a multiply.
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    issue(1'b1, 1'b0, 32'd6, 32'd7);                   wait_done();

    // Both starts together: multiply wins.
    issue(1'b1, 1'b1, 32'd9, 32'd3);                   wait_done();

    // Reset at cycle 15 of a multiply, with a start pulse during reset that must be ignored.
    issue(1'b1, 1'b0, 32'h0123_4567, 32'h0000_89AB);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    sbq.delete();
    last_r = '0;
    last_e = 1'b0;
    #1;
    chk(res == 32'd0, "midreset_result", 64'(res), 64'd0);
    chk(exc == 1'b0, "midreset_exception", 64'(exc), 64'd0);
    chk(rdy == 1'b0, "midreset_rdy", 64'(rdy), 64'd0);
    @(negedge clk);
    op_a  = 32'd5;
    op_b  = 32'd5;
    c_mul = 1'b1;
    @(negedge clk);
    c_mul = 1'b0;
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b1, 1'b0, 32'd2, 32'd3);                   wait_done();

    // Random mix with random gaps, so some operations are aborted by the next start.
    for (int i = 0; i < 60; i++) begin
      int          sel;
      int          gap;
      bit          m;
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      sel = $urandom_range(0, 9);
      m   = (sel < 4) || (sel == 9);
      d   = (sel >= 4);
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: begin
          a = {{28{a[31]}}, a[3:0]};
          b = {{28{b[31]}}, b[3:0]};
        end
        2: a = 32'h8000_0000;
        default: b = {{16{b[31]}}, b[15:0]};
      endcase
      issue(m, d, a, b);
      gap = $urandom_range(0, 45);
      repeat (gap) @(negedge clk);
    end
    wait_done();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
